data_mem: RTL and testbench

- Byte-addressable data memory for the single-cycle/multicycle MIPS datapath; sits behind the ALU address output in the MEM stage.
- Supports word, halfword and byte access sizes with big-endian byte ordering (MIPS convention).
- Registered read port (1-cycle latency) plus a dedicated byte output.
- Synchronous write from a 16-bit write-data bus.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/data_mem_lane_sel.sv | 43 ++++
 rtl/data_mem.sv | 76 +++++++
 tb/tb_data_mem.sv | 138 +++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants and helpers for the byte-addressable data memory.
// Access-size encodings match the MIPS datapath control field.
package mem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;

    localparam int MEM_DEPTH = 256;

    // Narrow four big-endian bytes (b[31:24] is the byte at A) to the access size.
    function automatic logic [31:0] rd_pack(input logic [1:0] sz, input logic [31:0] b);
        case (sz)
            SZ_BYTE: rd_pack = {24'h00_0000, b[31:24]};
            SZ_HALF: rd_pack = {16'h0000, b[31:16]};
            default: rd_pack = b;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_lane_sel.sv
// Maps an address and access size onto four wrapped byte indices, write enables
// and per-lane write bytes. Lane 0 is the byte at A (most significant).
module data_mem_lane_sel
    import mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0]      i_addr,
    input  logic [1:0]             i_size,
    input  logic [15:0]            i_wdata,
    output logic [3:0][ADDR_W-1:0] o_idx,
    output logic [3:0]             o_wen,
    output logic [31:0]            o_wbytes
);

    // Index arithmetic stays in ADDR_W bits so A+k wraps modulo DEPTH.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            o_idx[k] = i_addr + ADDR_W'(k);
        end
    end

    // Write lanes: o_wbytes[31:24] goes to A, [23:16] to A+1, and so on.
    always_comb begin
        o_wen    = 4'b0000;
        o_wbytes = 32'h0000_0000;
        case (i_size)
            SZ_BYTE: begin
                o_wen    = 4'b0001;
                o_wbytes = {i_wdata[7:0], 24'h00_0000};
            end
            SZ_HALF: begin
                o_wen    = 4'b0011;
                o_wbytes = {i_wdata, 16'h0000};
            end
            default: begin
                o_wen    = 4'b1111;
                o_wbytes = {16'h0000, i_wdata};
            end
        endcase
    end

endmodule

// File: rtl/data_mem.sv
// Byte-addressable big-endian data memory for the MIPS MEM stage:
// synchronous writes, registered read-before-write reads, wrap-around addressing.
module data_mem
    import mem_pkg::*;
#(
    parameter int DEPTH  = MEM_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        w_enable,
    input  logic        read,
    input  logic [31:0] address,
    input  logic [1:0]  byteaccess,
    input  logic [15:0] data_in,
    output logic [31:0] data_out,
    output logic [7:0]  data_out_byte
);

    logic [7:0]             r_mem [DEPTH];
    logic [31:0]            r_data_out;
    logic [7:0]             r_data_out_byte;

    logic [ADDR_W-1:0]      w_addr;
    logic [3:0][ADDR_W-1:0] w_idx;
    logic [3:0]             w_wen;
    logic [31:0]            w_wbytes;
    logic [31:0]            w_rd_bytes;
    logic                   w_unused_addr;

    assign w_addr        = address[ADDR_W-1:0];
    assign w_unused_addr = ^address[31:ADDR_W];

    data_mem_lane_sel #(
        .ADDR_W (ADDR_W)
    ) u_lane_sel (
        .i_addr   (w_addr),
        .i_size   (byteaccess),
        .i_wdata  (data_in),
        .o_idx    (w_idx),
        .o_wen    (w_wen),
        .o_wbytes (w_wbytes)
    );

    assign w_rd_bytes = {r_mem[w_idx[0]], r_mem[w_idx[1]], r_mem[w_idx[2]], r_mem[w_idx[3]]};

    // Storage array: reset clears every byte and takes priority over writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_enable) begin
            for (int k = 0; k < 4; k++) begin
                if (w_wen[k]) begin
                    r_mem[w_idx[k]] <= w_wbytes[31-8*k -: 8];
                end
            end
        end
    end

    // Read registers sample pre-edge array contents, giving read-before-write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out      <= 32'h0000_0000;
            r_data_out_byte <= 8'h00;
        end else if (read) begin
            r_data_out      <= rd_pack(byteaccess, w_rd_bytes);
            r_data_out_byte <= w_rd_bytes[31:24];
        end
    end

    assign data_out      = r_data_out;
    assign data_out_byte = r_data_out_byte;

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem with hand-computed expectations.
module tb_data_mem;

    logic        clk;
    logic        rst;
    logic        w_enable;
    logic        read;
    logic [31:0] address;
    logic [1:0]  byteaccess;
    logic [15:0] data_in;
    logic [31:0] data_out;
    logic [7:0]  data_out_byte;

    int checks = 0;
    int errors = 0;

    data_mem dut (
        .clk           (clk),
        .rst           (rst),
        .w_enable      (w_enable),
        .read          (read),
        .address       (address),
        .byteaccess    (byteaccess),
        .data_in       (data_in),
        .data_out      (data_out),
        .data_out_byte (data_out_byte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs at the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic r_s, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [1:0] sz, input logic [15:0] d);
        @(negedge clk);
        rst        = r_s;
        read       = rd;
        w_enable   = wr;
        address    = a;
        byteaccess = sz;
        data_in    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; read = 1'b0; w_enable = 1'b0;
        address = 32'h0; byteaccess = 2'b00; data_in = 16'h0;

        step(1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 16'h0);
        chk("reset_out", data_out, 32'h0000_0000);
        chk("reset_byte", {24'h0, data_out_byte}, 32'h0000_0000);

        // Arbitrary data, then a reset that also carries read/write strobes.
        step(1'b0, 1'b0, 1'b1, 32'h20, 2'b00, 16'hABCD);
        step(1'b0, 1'b1, 1'b0, 32'h20, 2'b00, 16'h0);
        chk("pre_reset_rd", data_out, 32'h0000_ABCD);
        step(1'b1, 1'b1, 1'b1, 32'h20, 2'b00, 16'h5555);
        chk("reset_ovr_out", data_out, 32'h0000_0000);
        chk("reset_ovr_byte", {24'h0, data_out_byte}, 32'h0000_0000);
        step(1'b0, 1'b1, 1'b0, 32'h20, 2'b00, 16'h0);
        chk("reset_cleared20", data_out, 32'h0000_0000);
        step(1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 16'h0);
        chk("reset_cleared0", data_out, 32'h0000_0000);

        // Word write/read at 0x9.
        step(1'b0, 1'b0, 1'b1, 32'h9, 2'b00, 16'h1337);
        step(1'b0, 1'b1, 1'b0, 32'h9, 2'b00, 16'h0);
        chk("word_rd", data_out, 32'h0000_1337);
        chk("word_rd_byte", {24'h0, data_out_byte}, 32'h0000_0000);
        step(1'b0, 1'b1, 1'b0, 32'hB, 2'b01, 16'h0);
        chk("word_mem11", data_out, 32'h0000_0013);

        // Read-before-write at the same edge.
        step(1'b0, 1'b1, 1'b1, 32'h9, 2'b00, 16'h222B);
        chk("rbw_old", data_out, 32'h0000_1337);
        step(1'b0, 1'b1, 1'b0, 32'h9, 2'b00, 16'h0);
        chk("rbw_new", data_out, 32'h0000_222B);

        // Halfword 0x00AD at 0xA: mem[A]=00 mem[B]=AD, mem[C]=2B untouched.
        step(1'b0, 1'b0, 1'b1, 32'hA, 2'b10, 16'h00AD);
        step(1'b0, 1'b1, 1'b0, 32'hA, 2'b10, 16'h0);
        chk("half_rd", data_out, 32'h0000_00AD);
        chk("half_rd_byte", {24'h0, data_out_byte}, 32'h0000_0000);
        step(1'b0, 1'b1, 1'b0, 32'hB, 2'b01, 16'h0);
        chk("byte_rd", data_out, 32'h0000_00AD);
        chk("byte_rd_byte", {24'h0, data_out_byte}, 32'h0000_00AD);
        step(1'b0, 1'b1, 1'b0, 32'h9, 2'b00, 16'h0);
        chk("word_after_half", data_out, 32'h0000_AD2B);
        step(1'b0, 1'b1, 1'b0, 32'h9, 2'b11, 16'h0);
        chk("size11_word", data_out, 32'h0000_AD2B);

        // Byte write stores only data_in[7:0].
        step(1'b0, 1'b0, 1'b1, 32'h0, 2'b01, 16'h0FFA);
        step(1'b0, 1'b1, 1'b0, 32'h0, 2'b01, 16'h0);
        chk("bytew_rd", data_out, 32'h0000_00FA);
        chk("bytew_rd_byte", {24'h0, data_out_byte}, 32'h0000_00FA);
        step(1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 16'h0);
        chk("bytew_word", data_out, 32'hFA00_0000);

        // Wrap-around word at 0xFE.
        step(1'b0, 1'b0, 1'b1, 32'hFE, 2'b00, 16'hBEEF);
        step(1'b0, 1'b1, 1'b0, 32'hFE, 2'b00, 16'h0);
        chk("wrap_word", data_out, 32'h0000_BEEF);
        step(1'b0, 1'b1, 1'b0, 32'h0, 2'b01, 16'h0);
        chk("wrap_mem0", data_out, 32'h0000_00BE);
        step(1'b0, 1'b1, 1'b0, 32'hFF, 2'b10, 16'h0);
        chk("wrap_half", data_out, 32'h0000_00BE);
        chk("wrap_half_byte", {24'h0, data_out_byte}, 32'h0000_0000);

        // Hold: read=0 keeps outputs while inputs move.
        step(1'b0, 1'b0, 1'b0, 32'hB, 2'b01, 16'h1234);
        step(1'b0, 1'b0, 1'b0, 32'h55, 2'b00, 16'h9999);
        chk("hold_out", data_out, 32'h0000_00BE);
        chk("hold_byte", {24'h0, data_out_byte}, 32'h0000_0000);

        // Upper address bits are ignored.
        step(1'b0, 1'b1, 1'b0, 32'h0000_0109, 2'b00, 16'h0);
        chk("alias_word", data_out, 32'h0000_AD2B);
        step(1'b0, 1'b1, 1'b0, 32'hFFFF_FF0B, 2'b01, 16'h0);
        chk("alias_byte", {24'h0, data_out_byte}, 32'h0000_00AD);
        step(1'b0, 1'b0, 1'b1, 32'h0000_01F0, 2'b01, 16'h0077);
        step(1'b0, 1'b1, 1'b0, 32'hF0, 2'b01, 16'h0);
        chk("alias_write", data_out, 32'h0000_0077);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
